// File: rtl/d_latch_checker.sv
// d_latch_checker: cycle-based checker for an external D latch with
// complementary outputs and an active-high latch reset.
// The checker tracks the latch mode and predicts the latch output.
// It flags complement errors, transparent-mode mismatches and
// hold/lreset mismatches.
// Optional feature: define LATCH_CHK_STICKY_EN to build a sticky err_flag.
// Without it, err_flag is tied to 0.
module d_latch_checker #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d,
    input  logic       en,
    input  logic       lrst,
    input  logic       q,
    input  logic       qb,
    output logic [1:0] mode,
    output logic       exp_q,
    output logic       err_pulse,
    output logic [1:0] err_code,
    output logic [7:0] err_count,
    output logic       err_flag
);

    typedef enum logic [1:0] {
        ST_UNKNOWN     = 2'b00,
        ST_TRANSPARENT = 2'b01,
        ST_HOLD        = 2'b10,
        ST_LRESET      = 2'b11
    } state_t;

    localparam logic [1:0] SETTLE_LD = 2'(SETTLE);

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_COMP  = 2'b01;
    localparam logic [1:0] CODE_TRANS = 2'b10;
    localparam logic [1:0] CODE_HOLD  = 2'b11;

    state_t     state;
    state_t     state_nxt;

    logic       d_hist;
    logic       en_hist;
    logic [1:0] settle_cnt;
    logic       first_unk;
    logic       lrst_first;

    logic       viol_comp;
    logic       viol_trans;
    logic       viol_hold;
    logic       viol;
    logic [1:0] code_nxt;
    logic       settle_load;

    // State register: the checker reset returns the FSM to UNKNOWN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_UNKNOWN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: lrst beats en; leaving TRANSPARENT or LRESET
    // without en enters HOLD; otherwise the state is kept.
    always_comb begin
        state_nxt = state;
        if (lrst) begin
            state_nxt = ST_LRESET;
        end else if (en) begin
            state_nxt = ST_TRANSPARENT;
        end else if (state == ST_TRANSPARENT || state == ST_LRESET) begin
            state_nxt = ST_HOLD;
        end
    end

    // Output logic: mode reports the registered state directly.
    always_comb begin
        mode = state;
    end

    // Violation detection on the current sample against the current
    // prediction. The result is registered below.
    always_comb begin
        viol_comp  = (q == qb) && !(state == ST_UNKNOWN && first_unk);
        viol_trans = (state == ST_TRANSPARENT) && (settle_cnt == 2'd0) &&
                     (q != exp_q);
        viol_hold  = ((state == ST_HOLD) ||
                      (state == ST_LRESET && !lrst_first)) && (q != exp_q);
        viol       = viol_comp || viol_trans || viol_hold;
        code_nxt   = CODE_NONE;
        if (viol_comp) begin
            code_nxt = CODE_COMP;
        end else if (viol_trans) begin
            code_nxt = CODE_TRANS;
        end else if (viol_hold) begin
            code_nxt = CODE_HOLD;
        end
        settle_load = (en && !en_hist) || (d != d_hist);
    end

    // Prediction datapath: expected output, input history, settle window.
    // The predictor also tracks first-cycle markers for UNKNOWN and LRESET.
    always_ff @(posedge clk) begin
        if (!reset) begin
            exp_q      <= 1'b0;
            d_hist     <= 1'b0;
            en_hist    <= 1'b0;
            settle_cnt <= '0;
            first_unk  <= 1'b1;
            lrst_first <= 1'b0;
        end else begin
            if (lrst) begin
                exp_q <= 1'b0;
            end else if (en) begin
                exp_q <= d;
            end
            d_hist  <= d;
            en_hist <= en;
            if (settle_load) begin
                settle_cnt <= SETTLE_LD;
            end else if (settle_cnt != 2'd0) begin
                settle_cnt <= settle_cnt - 2'd1;
            end
            first_unk  <= 1'b0;
            lrst_first <= (state_nxt == ST_LRESET) && (state != ST_LRESET);
        end
    end

    // Error reporting: the pulse, the last code and a saturating count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_pulse <= 1'b0;
            err_code  <= CODE_NONE;
            err_count <= '0;
        end else begin
            err_pulse <= viol;
            if (viol) begin
                err_code <= code_nxt;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

`ifdef LATCH_CHK_STICKY_EN
    // Sticky flag: sets on the first violation and clears only on reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_flag <= 1'b0;
        end else if (viol) begin
            err_flag <= 1'b1;
        end
    end
`else
    assign err_flag = 1'b0;
`endif

endmodule

// File: doc/d_latch_checker.md
D_LATCH_CHECKER -- requirements
Module: d_latch_checker

Interface
REQ-001 Parameter SETTLE, default 1, meaning: number of clk cycles after an en rise or d change during which transparent-mode mismatches are ignored (range 0-3).
REQ-002 clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  synchronous, active-low checker reset; it is sampled on the rising edge of clk.
REQ-004 d  input  1  data input presented to the observed latch, synchronous to clk.
REQ-005 en  input  1  observed latch enable (active-high, transparent when 1).
REQ-006 lrst  input  1  observed latch reset (active-high, forces q=0).
REQ-007 q  input  1  observed latch true output.
REQ-008 qb  input  1  observed latch complement output.
REQ-009 mode  output  2  checker state: 00 UNKNOWN, 01 TRANSPARENT, 10 HOLD, 11 LRESET.
REQ-010 exp_q  output  1  expected latch output value.
REQ-011 err_pulse  output  1  one-cycle pulse when a violation is detected.
REQ-012 err_code  output  2  code of the last violation: 01 complement, 10 transparent mismatch, 11 hold mismatch; holds its value until the next violation.
REQ-013 err_count  output  8  count of violations, saturating.
REQ-014 err_flag  output  1  sticky violation flag (see Configuration).

Function
REQ-015 FSM next state is evaluated every cycle; priority: lrst=1 -> LRESET; else en=1 -> TRANSPARENT; else previous state in {TRANSPARENT, LRESET} -> HOLD; else the current state is retained.
REQ-016 On entry to or stay in LRESET, exp_q SHALL be 0.
REQ-017 In TRANSPARENT, exp_q SHALL equal d registered one cycle earlier.
REQ-018 On the TRANSPARENT->HOLD transition, exp_q SHALL freeze at the d sampled in the last cycle with en=1; it is held throughout HOLD.
REQ-019 In UNKNOWN, no value check occurs; only the complement check is active.
REQ-020 Complement check: q==qb in any cycle outside UNKNOWN's first cycle -> violation code 01.
REQ-021 Transparent check: q!=exp_q while TRANSPARENT, with the settle counter at 0 -> code 10; the settle counter loads SETTLE on an en rise or a d change and decrements to 0.
REQ-022 Hold/LRESET check: q!=exp_q while HOLD or LRESET -> code 11; there is no settle window except the first LRESET cycle.
REQ-023 Simultaneous violations: one err_pulse, one count increment; code priority is 01 > 10 > 11.
REQ-024 err_count increments by 1 per violation cycle and SHALL stick at 255 (no wrap).
REQ-025 Outputs are registered; err_pulse asserts in the cycle after the offending sample (latency 1).

Reset
REQ-026 With reset=0 at a clk edge, next cycle: mode=00, exp_q=0, err_pulse=0, err_code=00, err_count=0, err_flag=0, settle counter=0, d history=0.
REQ-027 Reset asserted mid-check overrides all other activity, including a violation in the same cycle (no count, no pulse).
REQ-028 The cycle after reset deasserts is treated as the first UNKNOWN cycle.

Configuration
REQ-029 Macro LATCH_CHK_STICKY_EN: when defined, err_flag SHALL set on the first violation and stay 1 until reset; when undefined, err_flag SHALL be constant 0 and no sticky register exists; the port list is identical in both builds.

Verification
REQ-030 reset=0 for 2 cycles with q=1,qb=1 -> all outputs 0, no err_pulse.
REQ-031 lrst=1, q=0, qb=1 for 3 cycles -> mode=11, exp_q=0, err_count=0.
REQ-032 en=1, d toggles 0->1, q follows one cycle later, qb=~q -> mode=01, no violation; then en=0 with d=1 held, d changes to 0, q stays 1 -> mode=10, exp_q=1, no violation.
REQ-033 HOLD with exp_q=1, q forced 0, qb=1 for one cycle -> err_pulse=1 one cycle later, err_code=11, err_count=1.
REQ-034 q=qb=1 during TRANSPARENT with q!=exp_q -> single err_pulse, err_code=01, err_count+1.
REQ-035 300 consecutive violation cycles -> err_count=255 and stays there; with LATCH_CHK_STICKY_EN, err_flag=1 until reset=0; without the macro, err_flag=0 throughout.
